// File: rtl/bscan_arbiter_pkg.sv
// Shared definitions for the Bscan channel arbiter.
// Holds the default word geometry, the tagged-word layout and a tag extractor.
package bscan_arbiter_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int TAGW_DEF  = 2;
  localparam int PW_DEF    = WIDTH_DEF - TAGW_DEF;

  // A JTAG word as carried on the Bscan channel: client tag in the MSBs.
  typedef struct packed {
    logic [TAGW_DEF-1:0] tag;
    logic [PW_DEF-1:0]   payload;
  } bscan_word_t;

  function automatic logic [TAGW_DEF-1:0] tag_of(input bscan_word_t w);
    return w.tag;
  endfunction

endpackage

// File: rtl/bscan_arbiter_if.sv
// Bus bundle between the arbiter, its clients and the Bscan block.
// Signals:
//   req_enq__ENA/v/RDY       per-client request handshake (v packed NREQ*PW)
//   toBscan_enq__ENA/v/RDY   tagged outbound word to Bscan
//   fromBscan_enq__ENA/v/RDY tagged inbound word from Bscan
//   rsp_enq__ENA/v/RDY       per-client response (shared payload)
//   dropCount                saturating count of inbound words with a bad tag
// Modports: slave = arbiter side, master = surrounding environment.
interface bscan_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int TAGW  = 2,
  parameter int PW    = WIDTH - TAGW
);
  logic [NREQ-1:0]    req_enq__ENA;
  logic [NREQ*PW-1:0] req_enq_v;
  logic [NREQ-1:0]    req_enq__RDY;
  logic               toBscan_enq__ENA;
  logic [WIDTH-1:0]   toBscan_enq_v;
  logic               toBscan_enq__RDY;
  logic               fromBscan_enq__ENA;
  logic [WIDTH-1:0]   fromBscan_enq_v;
  logic               fromBscan_enq__RDY;
  logic [NREQ-1:0]    rsp_enq__ENA;
  logic [PW-1:0]      rsp_enq_v;
  logic [NREQ-1:0]    rsp_enq__RDY;
  logic [15:0]        dropCount;

  modport slave (
    input  req_enq__ENA, req_enq_v, toBscan_enq__RDY,
    input  fromBscan_enq__ENA, fromBscan_enq_v, rsp_enq__RDY,
    output req_enq__RDY, toBscan_enq__ENA, toBscan_enq_v,
    output fromBscan_enq__RDY, rsp_enq__ENA, rsp_enq_v, dropCount
  );

  modport master (
    output req_enq__ENA, req_enq_v, toBscan_enq__RDY,
    output fromBscan_enq__ENA, fromBscan_enq_v, rsp_enq__RDY,
    input  req_enq__RDY, toBscan_enq__ENA, toBscan_enq_v,
    input  fromBscan_enq__RDY, rsp_enq__ENA, rsp_enq_v, dropCount
  );

endinterface

// File: rtl/bscan_rr_arbiter.sv
// Round-robin arbiter over N request lines.
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset (clears the pointer)
//   req_i         request vector (full slots)
//   en_i          grant is consumed this cycle; advance the pointer
//   gnt_o         one-hot grant
//   idx_o         grant index
//   any_o         at least one request present
//   ptr_o         current search start position
module bscan_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [N-1:0]  req_i,
  input  logic          en_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o,
  output logic [IW-1:0] ptr_o
);

  logic [IW-1:0] ptr_q, ptr_d;
  int            c;

  // Search starts at the pointer and wraps; empty slots are skipped in the
  // same cycle so no grant opportunity is lost.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    c     = 0;
    for (int k = 0; k < N; k++) begin
      c = (int'(ptr_q) + k) % N;
      if (!any_o && req_i[c]) begin
        any_o    = 1'b1;
        idx_o    = IW'(c);
        gnt_o[c] = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (en_i && any_o) begin
      if (int'(idx_o) == N - 1) ptr_d = '0;
      else                      ptr_d = idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/bscan_arbiter.sv
// Shares the Bscan JTAG user-register channel among NREQ clients.
// Outbound: per-client one-entry slots -> round-robin -> obuf -> toBscan,
// each word tagged with the client index in its MSBs.
// Inbound: fromBscan -> rbuf -> routed by tag to rsp; bad tags are dropped
// and counted.
// Ports:
//   CLK, RST  system clock, synchronous active-high reset
//   bus       bscan_arbiter_if.slave (request, toBscan, fromBscan, rsp, dropCount)
module bscan_arbiter
  import bscan_arbiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREQ  = 4,
  parameter int TAGW  = TAGW_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  bscan_arbiter_if.slave bus
);

  localparam int PW = WIDTH - TAGW;
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]  slot_v_q, slot_v_d;
  logic [PW-1:0]    slot_q [NREQ];
  logic             obuf_v_q, obuf_v_d;
  logic [WIDTH-1:0] obuf_q;
  logic             rbuf_v_q, rbuf_v_d;
  logic [WIDTH-1:0] rbuf_q;
  logic [15:0]      drop_q, drop_d;

  logic [NREQ-1:0]  slot_load;
  logic [NREQ-1:0]  gnt;
  logic [IW-1:0]    gnt_idx;
  logic [IW-1:0]    ptr;
  logic             gnt_any;
  logic             arb_en;
  logic             rbuf_load;
  logic             rbuf_clr;
  logic [TAGW-1:0]  rtag;
  logic             rtag_ok;

  // Request stage: slot RDY comes straight from the registered valid, so it
  // never depends on ENA and a slot cannot refill in its grant cycle.
  assign slot_load        = bus.req_enq__ENA & ~slot_v_q;
  assign bus.req_enq__RDY = ~slot_v_q;

  // obuf may be refilled when empty or when it drains this cycle.
  assign arb_en = !obuf_v_q || bus.toBscan_enq__RDY;

  bscan_rr_arbiter #(.N(NREQ), .IW(IW)) u_rr (
    .clk_i (CLK),
    .rst_i (RST),
    .req_i (slot_v_q),
    .en_i  (arb_en),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any),
    .ptr_o (ptr)
  );

  always_comb begin
    slot_v_d = (slot_v_q | slot_load) & ~(arb_en ? gnt : '0);
    obuf_v_d = obuf_v_q;
    if (arb_en) obuf_v_d = gnt_any;
  end

  // Outbound stage
  assign bus.toBscan_enq__ENA = obuf_v_q;
  assign bus.toBscan_enq_v    = obuf_q;

  // Inbound stage: the tag needs one extra bit of headroom to compare
  // against NREQ when NREQ == 2^TAGW.
  assign rtag      = rbuf_q[WIDTH-1 -: TAGW];
  assign rtag_ok   = ({1'b0, rtag} < (TAGW+1)'(NREQ));
  assign rbuf_load = bus.fromBscan_enq__ENA && !rbuf_v_q;
  assign rbuf_clr  = rbuf_v_q && (rtag_ok ? bus.rsp_enq__RDY[rtag] : 1'b1);

  assign bus.fromBscan_enq__RDY = !rbuf_v_q;
  assign bus.rsp_enq_v          = rbuf_q[PW-1:0];
  assign bus.dropCount          = drop_q;

  always_comb begin
    bus.rsp_enq__ENA = '0;
    if (rbuf_v_q && rtag_ok) bus.rsp_enq__ENA[rtag] = 1'b1;
  end

  always_comb begin
    rbuf_v_d = rbuf_v_q;
    if (rbuf_load)     rbuf_v_d = 1'b1;
    else if (rbuf_clr) rbuf_v_d = 1'b0;
    drop_d = drop_q;
    if (rbuf_v_q && !rtag_ok && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      slot_v_q <= '0;
      obuf_v_q <= 1'b0;
      rbuf_v_q <= 1'b0;
      drop_q   <= '0;
    end else begin
      slot_v_q <= slot_v_d;
      obuf_v_q <= obuf_v_d;
      rbuf_v_q <= rbuf_v_d;
      drop_q   <= drop_d;
    end
  end

  // Data registers carry no reset; their valids gate every use.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NREQ; i++) begin
      if (slot_load[i]) slot_q[i] <= bus.req_enq_v[i*PW +: PW];
    end
    if (arb_en && gnt_any) obuf_q <= {TAGW'(gnt_idx), slot_q[gnt_idx]};
    if (rbuf_load) rbuf_q <= bus.fromBscan_enq_v;
  end

endmodule

// File: tb/tb_bscan_arbiter.sv
// Self-checking bench for bscan_arbiter: a 4-client instance for the main
// traffic and a 3-client instance for invalid-tag handling.
module tb_bscan_arbiter;
  import bscan_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bscan_arbiter_if #(.WIDTH(32), .NREQ(4), .TAGW(2)) bus ();
  bscan_arbiter_if #(.WIDTH(32), .NREQ(3), .TAGW(2)) bus3 ();

  bscan_arbiter #(.WIDTH(32), .NREQ(4), .TAGW(2)) dut (
    .CLK(clk), .RST(rst), .bus(bus.slave)
  );
  bscan_arbiter #(.WIDTH(32), .NREQ(3), .TAGW(2)) dut3 (
    .CLK(clk), .RST(rst), .bus(bus3.slave)
  );

  int total = 0;
  int bad   = 0;

  logic [29:0] exp_q [4][$];
  logic [31:0] rsp_exp_q [$];
  logic [3:0]  feed;
  logic        rr_mode;
  logic        prev_ok;
  int          prev_tag;
  bscan_word_t mon_w;
  logic [31:0] mon_r;
  int          mon_t;
  bscan_word_t held;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic int qsize();
    int s;
    s = 0;
    for (int i = 0; i < 4; i++) s += exp_q[i].size();
    return s;
  endfunction

  // One clock; strobes drop back to 0 and the auto-feeder refills any
  // fed client whose slot is free.
  task automatic cycle();
    logic [29:0] p;
    @(posedge clk);
    #1;
    bus.req_enq__ENA        = '0;
    bus.fromBscan_enq__ENA  = 1'b0;
    bus3.fromBscan_enq__ENA = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (feed[i] && bus.req_enq__RDY[i]) begin
        p = 30'($urandom);
        bus.req_enq__ENA[i]       = 1'b1;
        bus.req_enq_v[i*30 +: 30] = p;
        exp_q[i].push_back(p);
      end
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((qsize() != 0 || bus.toBscan_enq__ENA) && n < 100) begin
      cycle();
      n++;
    end
    chk(name, 64'(qsize()), 0);
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_reqrdy"}, bus.req_enq__RDY, 4'hF);
    chk({name, "_toena"}, bus.toBscan_enq__ENA, 0);
    chk({name, "_fromrdy"}, bus.fromBscan_enq__RDY, 1);
    chk({name, "_rspena"}, bus.rsp_enq__ENA, 0);
    chk({name, "_drop"}, bus.dropCount, 0);
    chk({name, "_fromrdy3"}, bus3.fromBscan_enq__RDY, 1);
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.toBscan_enq__ENA && bus.toBscan_enq__RDY) begin
        mon_w = bus.toBscan_enq_v;
        mon_t = int'(tag_of(mon_w));
        if (exp_q[mon_t].size() == 0) chk("out_extra", 64'(exp_q[mon_t].size()), 1);
        else chk("out_payload", mon_w.payload, exp_q[mon_t].pop_front());
        if (rr_mode) begin
          if (prev_ok) chk("rr_order", 64'(mon_t), 64'((prev_tag + 1) % 4));
          prev_tag = mon_t;
          prev_ok  = 1'b1;
        end
      end
      if (|(bus.rsp_enq__ENA & bus.rsp_enq__RDY)) begin
        if (rsp_exp_q.size() == 0) chk("rsp_extra", 64'(rsp_exp_q.size()), 1);
        else begin
          mon_r = rsp_exp_q.pop_front();
          chk("rsp_route", bus.rsp_enq__ENA, 64'(1) << mon_r[31:30]);
          chk("rsp_payload", bus.rsp_enq_v, mon_r[29:0]);
        end
      end
    end
  end

  initial begin
    logic [31:0] w;
    rst = 1'b1;
    feed = '0;
    rr_mode = 1'b0;
    prev_ok = 1'b0;
    prev_tag = 0;
    bus.req_enq__ENA = '0;
    bus.req_enq_v = '0;
    bus.toBscan_enq__RDY = 1'b1;
    bus.fromBscan_enq__ENA = 1'b0;
    bus.fromBscan_enq_v = '0;
    bus.rsp_enq__RDY = 4'hF;
    bus3.req_enq__ENA = '0;
    bus3.req_enq_v = '0;
    bus3.toBscan_enq__RDY = 1'b1;
    bus3.fromBscan_enq__ENA = 1'b0;
    bus3.fromBscan_enq_v = '0;
    bus3.rsp_enq__RDY = 3'h7;

    repeat (3) cycle();
    rst = 1'b0;
    cycle();
    chk_idle("reset");

    // Single word from client 2.
    bus.req_enq__ENA[2] = 1'b1;
    bus.req_enq_v[2*30 +: 30] = 30'h1234567;
    exp_q[2].push_back(30'h1234567);
    cycle();
    chk("single_t1_ena", bus.toBscan_enq__ENA, 0);
    chk("single_t1_rdy2", bus.req_enq__RDY[2], 0);
    cycle();
    chk("single_t2_ena", bus.toBscan_enq__ENA, 1);
    chk("single_t2_v", bus.toBscan_enq_v, 32'h81234567);
    chk("single_t2_rdy2", bus.req_enq__RDY[2], 1);
    cycle();
    chk("single_t3_ena", bus.toBscan_enq__ENA, 0);
    chk("single_q", 64'(qsize()), 0);

    // Fairness under continuous load.
    feed = 4'hF;
    rr_mode = 1'b1;
    prev_ok = 1'b0;
    repeat (40) cycle();
    rr_mode = 1'b0;
    feed = '0;
    drain("fair_drain");

    // Backpressure: obuf holds while slots fill.
    bus.toBscan_enq__RDY = 1'b0;
    feed = 4'hF;
    repeat (3) cycle();
    chk("bp_ena", bus.toBscan_enq__ENA, 1);
    held = bus.toBscan_enq_v;
    chk("bp_head", held.payload, exp_q[int'(held.tag)][0]);
    repeat (10) begin
      cycle();
      chk("bp_hold", bus.toBscan_enq_v, held);
    end
    chk("bp_full", bus.req_enq__RDY, 4'h0);
    feed = '0;
    cycle();
    rr_mode = 1'b1;
    prev_ok = 1'b0;
    bus.toBscan_enq__RDY = 1'b1;
    drain("bp_drain");
    rr_mode = 1'b0;

    // Response routing with a stalled client.
    bus.rsp_enq__RDY = 4'b1101;
    bus.fromBscan_enq__ENA = 1'b1;
    bus.fromBscan_enq_v = 32'h40000ABC;
    rsp_exp_q.push_back(32'h40000ABC);
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("rsp_hold_ena", bus.rsp_enq__ENA, 4'b0010);
      chk("rsp_hold_v", bus.rsp_enq_v, 30'h0000ABC);
      chk("rsp_hold_rdy", bus.fromBscan_enq__RDY, 0);
    end
    bus.rsp_enq__RDY = 4'hF;
    cycle();
    chk("rsp_done_ena", bus.rsp_enq__ENA, 0);
    chk("rsp_done_rdy", bus.fromBscan_enq__RDY, 1);
    for (int t = 0; t < 4; t++) begin
      w = {2'(t), 30'($urandom)};
      bus.fromBscan_enq__ENA = 1'b1;
      bus.fromBscan_enq_v = w;
      rsp_exp_q.push_back(w);
      cycle();
      chk("rsp_each_ena", bus.rsp_enq__ENA, 64'(1) << t);
      cycle();
    end
    chk("rsp_q", 64'(rsp_exp_q.size()), 0);
    chk("drop4", bus.dropCount, 0);

    // Invalid tag on the 3-client instance, then a valid tag 2.
    bus3.fromBscan_enq__ENA = 1'b1;
    bus3.fromBscan_enq_v = 32'hC0000001;
    cycle();
    chk("bad_t1_ena", bus3.rsp_enq__ENA, 0);
    chk("bad_t1_rdy", bus3.fromBscan_enq__RDY, 0);
    chk("bad_t1_drop", bus3.dropCount, 0);
    cycle();
    chk("bad_t2_drop", bus3.dropCount, 1);
    chk("bad_t2_rdy", bus3.fromBscan_enq__RDY, 1);
    chk("bad_t2_ena", bus3.rsp_enq__ENA, 0);
    bus3.fromBscan_enq__ENA = 1'b1;
    bus3.fromBscan_enq_v = 32'h80000055;
    cycle();
    chk("n3_ena", bus3.rsp_enq__ENA, 3'b100);
    chk("n3_v", bus3.rsp_enq_v, 30'h55);
    cycle();
    chk("n3_drop", bus3.dropCount, 1);

    // Reset in the middle of traffic discards everything.
    bus.toBscan_enq__RDY = 1'b0;
    bus.rsp_enq__RDY = 4'b1110;
    feed = 4'hF;
    bus.fromBscan_enq__ENA = 1'b1;
    bus.fromBscan_enq_v = 32'h00000123;
    repeat (4) cycle();
    feed = '0;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) exp_q[i].delete();
    rsp_exp_q.delete();
    bus.req_enq__ENA = '0;
    cycle();
    chk_idle("midrst");
    rst = 1'b0;
    bus.toBscan_enq__RDY = 1'b1;
    bus.rsp_enq__RDY = 4'hF;
    cycle();
    chk_idle("postrst");

    // Traffic resumes after reset.
    bus.req_enq__ENA[0] = 1'b1;
    bus.req_enq_v[0 +: 30] = 30'h0BADF00;
    exp_q[0].push_back(30'h0BADF00);
    cycle();
    cycle();
    chk("post_v", bus.toBscan_enq_v, 32'h00BADF00);
    drain("post_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
